// File: rtl/wb_master_pkg.sv
// Shared definitions for the Wishbone single-transaction initiator:
// FSM state encoding, default timeout and bus width constants.
package wb_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;
    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

endpackage

// File: rtl/wb_master_ctrl.sv
// Command-to-Wishbone bridge: accepts one command, runs one classic Wishbone
// cycle with a stb timeout, and returns the result over a response handshake.
module wb_master_ctrl
    import wb_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [SEL_W-1:0] cmd_sel,
    input  logic [ADR_W-1:0] cmd_adr,
    input  logic [DAT_W-1:0] cmd_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DAT_W-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [SEL_W-1:0] wbm_sel_o,
    output logic [ADR_W-1:0] wbm_adr_o,
    output logic [DAT_W-1:0] wbm_dat_o,
    input  logic             wbm_ack_i,
    input  logic [DAT_W-1:0] wbm_dat_i
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Value the counter holds during the last permitted stb cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               cyc_q, cyc_d;
    logic               stb_q, stb_d;
    logic               we_q, we_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [ADR_W-1:0]   adr_q, adr_d;
    logic [DAT_W-1:0]   dat_q, dat_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DAT_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    we_d    = cmd_we;
                    sel_d   = cmd_sel;
                    adr_d   = cmd_adr;
                    dat_d   = cmd_wdata;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                // Ack is checked first so an ack on the final cycle beats the timeout.
                if (wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_rdata_d = we_q ? '0 : wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = stb_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_wb_master_ctrl.sv
// Self-checking bench for wb_master_ctrl: vector table of single transactions
// with a response scoreboard, plus back-to-back and reset-abort sequences.
module tb_wb_master_ctrl;

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [3:0]  cmd_sel;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] wdata;
        int          ackDelay;
        logic [31:0] ackDat;
        int          rspWait;
        int          expStb;
        logic [31:0] expRdata;
        logic        expErr;
    } vec_t;

    rsp_t expQ[$];
    vec_t vecs[7];
    int   errors = 0;
    int   checks = 0;

    wb_master_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_sel   (cmd_sel),
        .cmd_adr   (cmd_adr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_i (wbm_ack_i),
        .wbm_dat_i (wbm_dat_i)
    );

    initial begin
        wb_clk_i = 1'b0;
        forever #5 wb_clk_i = ~wb_clk_i;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h required 0x%08h", name, actual, expected);
        end
    endtask

    task automatic popAndCompare(input string tag);
        rsp_t exp;
        if (expQ.size() == 0) begin
            checkOutput({tag, "_sbUnderflow"}, 32'd0, 32'd1);
        end else begin
            exp = expQ.pop_front();
            checkOutput({tag, "_rdata"}, rsp_rdata, exp.rdata);
            checkOutput({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp.err});
        end
    endtask

    // One full transaction: command handshake, responder, response backpressure.
    task automatic applyStimulus(input int idx, input vec_t v);
        int          guard;
        int          stbCycles;
        bit          stable;
        logic [31:0] holdData;
        logic        holdErr;
        string       tag;
        tag = $sformatf("vec%0d", idx);

        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 50) begin
            @(negedge wb_clk_i);
            guard++;
        end
        checkOutput({tag, "_cmdReadyWait"}, {31'd0, cmd_ready}, 32'd1);

        cmd_valid = 1'b1;
        cmd_we    = v.we;
        cmd_sel   = v.sel;
        cmd_adr   = v.adr;
        cmd_wdata = v.wdata;
        @(posedge wb_clk_i);
        expQ.push_back('{v.expRdata, v.expErr});
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
        cmd_we    = ~v.we;
        cmd_sel   = 4'($urandom);
        cmd_adr   = $urandom;
        cmd_wdata = $urandom;

        checkOutput({tag, "_cmdReadyBus"}, {31'd0, cmd_ready}, 32'd0);
        checkOutput({tag, "_adr"}, wbm_adr_o, v.adr);
        checkOutput({tag, "_sel"}, {28'd0, wbm_sel_o}, {28'd0, v.sel});
        checkOutput({tag, "_we"}, {31'd0, wbm_we_o}, {31'd0, v.we});
        checkOutput({tag, "_datO"}, wbm_dat_o, v.wdata);

        stbCycles = 0;
        stable    = 1'b1;
        while (wbm_stb_o === 1'b1 && stbCycles < 100) begin
            stbCycles++;
            if (wbm_cyc_o !== 1'b1 || wbm_adr_o !== v.adr || wbm_sel_o !== v.sel ||
                wbm_we_o !== v.we || wbm_dat_o !== v.wdata || cmd_ready !== 1'b0 ||
                rsp_valid !== 1'b0)
                stable = 1'b0;
            if (stbCycles - 1 == v.ackDelay) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = v.ackDat;
            end
            @(negedge wb_clk_i);
            wbm_ack_i = 1'b0;
            wbm_dat_i = $urandom;
        end
        checkOutput({tag, "_stbCycles"}, stbCycles, v.expStb);
        checkOutput({tag, "_busStable"}, {31'd0, stable}, 32'd1);
        checkOutput({tag, "_cycDropped"}, {31'd0, wbm_cyc_o}, 32'd0);
        checkOutput({tag, "_rspValid"}, {31'd0, rsp_valid}, 32'd1);

        holdData = rsp_rdata;
        holdErr  = rsp_err;
        stable   = 1'b1;
        for (int i = 0; i < v.rspWait; i++) begin
            wbm_ack_i = (i == 1);
            wbm_dat_i = 32'hBAD0BAD0;
            @(negedge wb_clk_i);
            if (rsp_valid !== 1'b1 || rsp_rdata !== holdData || rsp_err !== holdErr ||
                cmd_ready !== 1'b0 || wbm_cyc_o !== 1'b0)
                stable = 1'b0;
        end
        wbm_ack_i = 1'b0;
        checkOutput({tag, "_rspHold"}, {31'd0, stable}, 32'd1);

        rsp_ready = 1'b1;
        popAndCompare(tag);
        @(negedge wb_clk_i);
        rsp_ready = 1'b0;
        checkOutput({tag, "_rspDone"}, {31'd0, rsp_valid}, 32'd0);
        checkOutput({tag, "_cmdReadyAfter"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        int  accepts;
        int  lastAcc;
        bit  sawRsp;

        //              we    sel    adr            wdata         ackDly ackDat         wait stb rdata          err
        vecs[0] = '{1'b1, 4'hF, 32'h3000_0000, 32'h0000_0001,  1, 32'hAAAA_5555, 0,  2, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b0, 4'hF, 32'h3000_0000, 32'h0000_0000,  3, 32'h0000_0001, 0,  4, 32'h0000_0001, 1'b0};
        vecs[2] = '{1'b0, 4'h3, 32'h4000_0010, 32'h0000_0000, -1, 32'h0000_0000, 0, 16, 32'h0000_0000, 1'b1};
        vecs[3] = '{1'b0, 4'hF, 32'h4000_0020, 32'h0000_0000, 15, 32'hDEAD_BEEF, 0, 16, 32'hDEAD_BEEF, 1'b0};
        vecs[4] = '{1'b0, 4'hC, 32'h1000_0004, 32'h0000_0000,  0, 32'hCAFE_F00D, 5,  1, 32'hCAFE_F00D, 1'b0};
        vecs[5] = '{1'b1, 4'h1, 32'h0000_0020, 32'h0000_0055, -1, 32'h0000_0000, 2, 16, 32'h0000_0000, 1'b1};
        vecs[6] = '{1'b1, 4'h6, 32'h8000_0100, 32'h1234_ABCD,  0, 32'hFFFF_FFFF, 0,  1, 32'h0000_0000, 1'b0};

        wb_rst_i  = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_sel   = 4'h0;
        cmd_adr   = 32'h0;
        cmd_wdata = 32'h0;
        rsp_ready = 1'b0;
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;

        @(negedge wb_clk_i);
        checkOutput("rst_cmdReady", {31'd0, cmd_ready}, 32'd0);
        checkOutput("rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        checkOutput("rst_stb", {31'd0, wbm_stb_o}, 32'd0);
        checkOutput("rst_rspValid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rst_rspErr", {31'd0, rsp_err}, 32'd0);
        checkOutput("rst_rdata", rsp_rdata, 32'd0);
        checkOutput("rst_adr", wbm_adr_o, 32'd0);
        wb_rst_i = 1'b0;
        #1;
        checkOutput("rel_cmdReadyBeforeEdge", {31'd0, cmd_ready}, 32'd0);
        @(negedge wb_clk_i);
        checkOutput("rel_cmdReadyAfterEdge", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < 7; i++) applyStimulus(i, vecs[i]);

        // Back-to-back: zero-wait ack and rsp_ready held high.
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_sel   = 4'hF;
        cmd_adr   = 32'h5000_0000;
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h1234_5678;
        rsp_ready = 1'b1;
        accepts   = 0;
        lastAcc   = -1;
        for (int c = 0; c < 60 && !(accepts == 3 && expQ.size() == 0); c++) begin
            if (accepts == 3) cmd_valid = 1'b0;
            if (cmd_ready === 1'b1 && cmd_valid) begin
                if (lastAcc >= 0) checkOutput("b2b_spacing", c - lastAcc, 32'd3);
                lastAcc = c;
                accepts++;
                expQ.push_back('{32'h1234_5678, 1'b0});
            end
            if (rsp_valid === 1'b1) popAndCompare("b2b");
            @(negedge wb_clk_i);
        end
        checkOutput("b2b_accepts", accepts, 32'd3);
        cmd_valid = 1'b0;
        wbm_ack_i = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge wb_clk_i);

        // Reset two cycles into BUS aborts the transaction with no response.
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_sel   = 4'hF;
        cmd_adr   = 32'h6000_0000;
        cmd_wdata = 32'h0000_00AA;
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
        @(negedge wb_clk_i);
        checkOutput("abort_stbBefore", {31'd0, wbm_stb_o}, 32'd1);
        #2 wb_rst_i = 1'b1;
        #1;
        checkOutput("abort_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        checkOutput("abort_stb", {31'd0, wbm_stb_o}, 32'd0);
        checkOutput("abort_rspValid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("abort_cmdReady", {31'd0, cmd_ready}, 32'd0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        checkOutput("abort_cmdReadyAfter", {31'd0, cmd_ready}, 32'd1);
        rsp_ready = 1'b1;
        sawRsp    = 1'b0;
        repeat (20) begin
            @(negedge wb_clk_i);
            if (rsp_valid !== 1'b0 || wbm_stb_o !== 1'b0) sawRsp = 1'b1;
        end
        checkOutput("abort_noResponse", {31'd0, sawRsp}, 32'd0);

        checkOutput("sb_drained", expQ.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
